// File: rtl/snake_pkg.sv
// Shared dmem widths and read-owner encoding for the dmem port arbiter.
package snake_pkg;
    localparam int DMEM_ADDR_W = 12;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_P_RD = 2'd1,
        OWN_V_RD = 2'd2
    } own_e;
endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != MAX_V))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_V);
endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single dmem port between the processor (rd/wr) and VGA fetch (rd),
// with an anti-starvation slot for VGA and per-read owner tagging of returned data.
module dmem_port_arbiter
    import snake_pkg::*;
#(
    parameter int ADDR_W     = DMEM_ADDR_W,
    parameter int DATA_W     = DMEM_DATA_W,
    parameter int STARVE_MAX = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              p_req,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_data,
    output logic              p_stall,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_gnt,
    output logic              v_rvalid,
    output logic [DATA_W-1:0] v_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_data,
    output logic              dm_wren,
    input  logic [DATA_W-1:0] dm_q
);
    logic       proc_gnt, vga_gnt;
    logic       starve_at_max;
    logic [7:0] starve_cnt;
    logic       unused_starve_cnt;
    own_e       state_d, state_q;

    assign unused_starve_cnt = ^starve_cnt;

    sat_counter #(.WIDTH(8), .MAX(STARVE_MAX)) u_starve (
        .clock  (clock),
        .resetn (resetn),
        .inc    (v_req & ~vga_gnt),
        .clr    (vga_gnt | ~v_req),
        .count  (starve_cnt),
        .at_max (starve_at_max)
    );

    // A processor write always wins, even over a starved VGA request.
    always_comb begin
        proc_gnt = 1'b0;
        vga_gnt  = 1'b0;
        if (resetn) begin
            if (p_req && p_wren)
                proc_gnt = 1'b1;
            else if (v_req && starve_at_max)
                vga_gnt = 1'b1;
            else if (p_req)
                proc_gnt = 1'b1;
            else if (v_req)
                vga_gnt = 1'b1;
        end
    end

    always_comb begin
        dm_addr = '0;
        dm_data = '0;
        dm_wren = 1'b0;
        if (proc_gnt) begin
            dm_addr = p_addr;
            dm_data = p_data;
            dm_wren = p_wren;
        end else if (vga_gnt) begin
            dm_addr = v_addr;
        end
    end

    assign p_stall = p_req & ~proc_gnt & resetn;
    assign v_gnt   = vga_gnt;

    // State records who owns the dm_q word that arrives next cycle.
    always_comb begin
        state_d = OWN_IDLE;
        if (proc_gnt && !p_wren)
            state_d = OWN_P_RD;
        else if (vga_gnt)
            state_d = OWN_V_RD;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            state_q <= OWN_IDLE;
        else
            state_q <= state_d;
    end

    assign p_rvalid = (state_q == OWN_P_RD);
    assign v_rvalid = (state_q == OWN_V_RD);
    assign p_rdata  = p_rvalid ? dm_q : '0;
    assign v_rdata  = v_rvalid ? dm_q : '0;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter with a negedge-sampling dmem model.
module tb_dmem_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          resetn;
    logic          p_req, p_wren;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    logic          p_stall, p_rvalid;
    logic [DW-1:0] p_rdata;
    logic          v_req;
    logic [AW-1:0] v_addr;
    logic          v_gnt, v_rvalid;
    logic [DW-1:0] v_rdata;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_data;
    logic          dm_wren;
    logic [DW-1:0] dm_q = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(8)) dut (
        .clock(clock), .resetn(resetn),
        .p_req(p_req), .p_wren(p_wren), .p_addr(p_addr), .p_data(p_data),
        .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt),
        .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .dm_addr(dm_addr), .dm_data(dm_data), .dm_wren(dm_wren), .dm_q(dm_q)
    );

    always #10 clock = ~clock;

    // dmem samples on the falling edge; q holds until the next falling edge
    always @(negedge clock) begin
        if (dm_wren) mem[dm_addr] <= dm_data;
        dm_q <= mem[dm_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        p_req = 0; p_wren = 0; p_addr = '0; p_data = '0;
        v_req = 0; v_addr = '0;
    endtask

    task automatic test_reset();
        resetn = 0;
        p_req = 1; p_wren = 1; p_addr = 12'h0AB; p_data = 32'h5555AAAA;
        v_req = 1; v_addr = 12'h0CD;
        #2;
        checks++;
        if ({p_stall, v_gnt, dm_wren, p_rvalid, v_rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000", {p_stall, v_gnt, dm_wren, p_rvalid, v_rvalid});
        end
        checks++;
        if ({dm_addr, dm_data, p_rdata, v_rdata} !== '0) begin
            errors++; $display("FAIL reset_buses got addr=%h data=%h prd=%h vrd=%h want 0", dm_addr, dm_data, p_rdata, v_rdata);
        end
        tick();
        // VGA read granted, then reset lands before the next rising edge
        resetn = 1; idle(); v_req = 1; v_addr = 12'h005;
        #2;
        checks++;
        if (v_gnt !== 1'b1 || dm_addr !== 12'h005) begin
            errors++; $display("FAIL midrd_grant got gnt=%b addr=%h want 1 005", v_gnt, dm_addr);
        end
        #2 resetn = 0;
        #2;
        checks++;
        if (v_gnt !== 1'b0 || dm_addr !== 12'h000 || p_stall !== 1'b0) begin
            errors++; $display("FAIL midrd_in_reset got gnt=%b addr=%h stall=%b want 0 000 0", v_gnt, dm_addr, p_stall);
        end
        tick();
        checks++;
        if (v_rvalid !== 1'b0 || v_rdata !== '0) begin
            errors++; $display("FAIL midrd_dropped got v_rvalid=%b v_rdata=%h want 0 0", v_rvalid, v_rdata);
        end
        resetn = 1; idle();
        #2;
        checks++;
        if (v_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin
            errors++; $display("FAIL release_rvalid got v=%b p=%b want 0 0", v_rvalid, p_rvalid);
        end
        tick();
        #2;
        checks++;
        if (v_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin
            errors++; $display("FAIL release_rvalid2 got v=%b p=%b want 0 0", v_rvalid, p_rvalid);
        end
        tick();
    endtask

    task automatic test_single_read();
        idle(); p_req = 1; p_addr = 12'h010;
        #2;
        checks++;
        if (p_stall !== 1'b0 || dm_addr !== 12'h010 || dm_wren !== 1'b0) begin
            errors++; $display("FAIL single_issue got stall=%b addr=%h wren=%b want 0 010 0", p_stall, dm_addr, dm_wren);
        end
        tick();
        idle();
        #2;
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'hDEADBEEF || v_rvalid !== 1'b0) begin
            errors++; $display("FAIL single_data got pv=%b prd=%h vv=%b want 1 deadbeef 0", p_rvalid, p_rdata, v_rvalid);
        end
        tick();
    endtask

    task automatic test_contention();
        logic prev_v;
        logic exp_v;
        prev_v = 0;
        idle(); p_req = 1; p_addr = 12'h020; v_req = 1; v_addr = 12'h030;
        for (int i = 0; i < 18; i++) begin
            exp_v = ((i % 9) == 8);
            #2;
            checks++;
            if (v_gnt !== exp_v || p_stall !== exp_v) begin
                errors++; $display("FAIL contend_grant cyc=%0d got v_gnt=%b p_stall=%b want %b %b", i, v_gnt, p_stall, exp_v, exp_v);
            end
            checks++;
            if (dm_addr !== (exp_v ? 12'h030 : 12'h020)) begin
                errors++; $display("FAIL contend_addr cyc=%0d got %h want %h", i, dm_addr, exp_v ? 12'h030 : 12'h020);
            end
            if (i > 0) begin
                checks++;
                if (p_rvalid !== !prev_v || v_rvalid !== prev_v ||
                    (prev_v ? v_rdata : p_rdata) !== (prev_v ? mem[12'h030] : mem[12'h020])) begin
                    errors++; $display("FAIL contend_tag cyc=%0d got pv=%b vv=%b prd=%h vrd=%h want prev_v=%b", i, p_rvalid, v_rvalid, p_rdata, v_rdata, prev_v);
                end
            end
            prev_v = exp_v;
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_write_starved();
        idle(); p_req = 1; p_addr = 12'h020; v_req = 1; v_addr = 12'h030;
        for (int i = 0; i < 8; i++) begin
            #2;
            checks++;
            if (v_gnt !== 1'b0) begin
                errors++; $display("FAIL starve_fill cyc=%0d got v_gnt=%b want 0", i, v_gnt);
            end
            tick();
        end
        p_wren = 1; p_addr = 12'h040; p_data = 32'h12345678;
        #2;
        checks++;
        if (dm_wren !== 1'b1 || v_gnt !== 1'b0 || p_stall !== 1'b0 ||
            dm_addr !== 12'h040 || dm_data !== 32'h12345678) begin
            errors++; $display("FAIL wr_beats_vga got wren=%b v_gnt=%b stall=%b addr=%h data=%h want 1 0 0 040 12345678", dm_wren, v_gnt, p_stall, dm_addr, dm_data);
        end
        tick();
        // a processor read now loses only if the count stayed saturated
        p_wren = 0; p_addr = 12'h020; p_data = '0;
        #2;
        checks++;
        if (v_gnt !== 1'b1 || p_stall !== 1'b1 || dm_wren !== 1'b0 || p_rvalid !== 1'b0) begin
            errors++; $display("FAIL starved_vga_slot got v_gnt=%b stall=%b wren=%b pv=%b want 1 1 0 0", v_gnt, p_stall, dm_wren, p_rvalid);
        end
        tick();
        v_req = 0; p_addr = 12'h040;
        #2;
        checks++;
        if (p_stall !== 1'b0 || v_rvalid !== 1'b1 || v_rdata !== mem[12'h030]) begin
            errors++; $display("FAIL post_slot got stall=%b vv=%b vrd=%h want 0 1 %h", p_stall, v_rvalid, v_rdata, mem[12'h030]);
        end
        tick();
        idle();
        #2;
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== 32'h12345678) begin
            errors++; $display("FAIL write_readback got pv=%b prd=%h want 1 12345678", p_rvalid, p_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        idle(); p_req = 1; p_addr = 12'h001;
        #2;
        checks++;
        if (p_stall !== 1'b0 || v_gnt !== 1'b0) begin
            errors++; $display("FAIL alt_p_issue got stall=%b v_gnt=%b want 0 0", p_stall, v_gnt);
        end
        tick();
        idle(); v_req = 1; v_addr = 12'h002;
        #2;
        checks++;
        if (v_gnt !== 1'b1 || p_rvalid !== 1'b1 || p_rdata !== 32'h11110001 ||
            v_rvalid !== 1'b0 || v_rdata !== '0) begin
            errors++; $display("FAIL alt_p_data got v_gnt=%b pv=%b prd=%h vv=%b vrd=%h want 1 1 11110001 0 0", v_gnt, p_rvalid, p_rdata, v_rvalid, v_rdata);
        end
        tick();
        idle();
        #2;
        checks++;
        if (v_rvalid !== 1'b1 || v_rdata !== 32'h22220002 ||
            p_rvalid !== 1'b0 || p_rdata !== '0) begin
            errors++; $display("FAIL alt_v_data got vv=%b vrd=%h pv=%b prd=%h want 1 22220002 0 0", v_rvalid, v_rdata, p_rvalid, p_rdata);
        end
        tick();
        #2;
        checks++;
        if (v_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin
            errors++; $display("FAIL alt_idle got vv=%b pv=%b want 0 0", v_rvalid, p_rvalid);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5000000 | i;
        mem[12'h010] = 32'hDEADBEEF;
        mem[12'h001] = 32'h11110001;
        mem[12'h002] = 32'h22220002;
        resetn = 0;
        idle();
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_write_starved();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
